// File: rtl/cache_pkg.sv
// cache_pkg: shared types and constants for the cache miss-fill controller.
//   - fill_state_e : fill FSM states
//   - geometry constants and miss-address field slices
`timescale 1ns/1ps
package cache_pkg;

  typedef enum logic [1:0] {IDLE, FILL, DONE} fill_state_e;

  localparam int NWAYS         = 2;
  localparam int NSETS         = 64;
  localparam int WORDS_PER_BLK = 8;
  localparam int WORD_W        = 16;

  // miss_addr fields: tag [15:10], set [9:4], word [3:1], byte [0]
  localparam int TAG_HI  = 15;
  localparam int TAG_LO  = 10;
  localparam int SET_HI  = 9;
  localparam int SET_LO  = 4;
  localparam int WORD_HI = 3;
  localparam int WORD_LO = 1;

  localparam int TAG_W  = TAG_HI - TAG_LO + 1;    // 6
  localparam int BASE_W = TAG_HI - SET_LO + 1;    // 12: tag+set, the block address
  localparam int WIDX_W = WORD_HI - WORD_LO + 1;  // 3

endpackage

// File: rtl/onehot_decoder.sv
// onehot_decoder: N-bit binary select to 2^N one-hot, all-zero when disabled.
//   en_i  : decode enable
//   sel_i : binary select
//   dec_o : one-hot output
`timescale 1ns/1ps
module onehot_decoder #(
  parameter int N = 3
) (
  input  logic              en_i,
  input  logic [N-1:0]      sel_i,
  output logic [(1<<N)-1:0] dec_o
);

  always_comb begin
    dec_o = '0;
    if (en_i) dec_o[sel_i] = 1'b1;
  end

endmodule

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: miss-handling fill controller for a 2-way set-associative
// cache. On a miss it requests the 8 words of the block, writes each returned
// word into the victim way, then pulses a one-cycle tag-array write.
//   clk, rst (async, active-low)
//   miss_detected/miss_addr/victim_way : miss request from hit/miss logic
//   mem_en/mem_addr                     : memory read requests
//   mem_data_valid/mem_data             : in-order memory returns
//   block_enable/word_enable/write_en*/data_out : data-array write port
//   write_tag_array/tag_out/tag_way     : tag-array write port
//   fsm_busy                            : high in FILL and DONE
`timescale 1ns/1ps
module cache_fill_fsm #(
  parameter int NSETS = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        miss_detected,
  input  logic [cache_pkg::WORD_W-1:0] miss_addr,
  input  logic                        victim_way,
  input  logic                        mem_data_valid,
  input  logic [cache_pkg::WORD_W-1:0] mem_data,
  output logic                        fsm_busy,
  output logic                        mem_en,
  output logic [cache_pkg::WORD_W-1:0] mem_addr,
  output logic [NSETS-1:0]            block_enable,
  output logic [cache_pkg::WORDS_PER_BLK-1:0] word_enable,
  output logic                        write_en0,
  output logic                        write_en1,
  output logic [cache_pkg::WORD_W-1:0] data_out,
  output logic                        write_tag_array,
  output logic [cache_pkg::TAG_W-1:0] tag_out,
  output logic                        tag_way
);
  import cache_pkg::*;

  localparam int SET_BITS = $clog2(NSETS);

  fill_state_e       state_q, state_d;
  logic [BASE_W-1:0] base_q, base_d;
  logic              way_q, way_d;
  logic [3:0]        issue_q, issue_d;  // requests issued, saturates at 8
  logic [2:0]        recv_q, recv_d;    // words written so far
  logic              wr;                // a returned word is written this cycle

  // byte offset and word index of the miss address are irrelevant: whole block is filled
  logic unused_addr_bits;
  assign unused_addr_bits = ^miss_addr[WORD_HI:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      way_q   <= 1'b0;
      issue_q <= '0;
      recv_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      way_q   <= way_d;
      issue_q <= issue_d;
      recv_q  <= recv_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    base_d          = base_q;
    way_d           = way_q;
    issue_d         = issue_q;
    recv_d          = recv_q;
    wr              = 1'b0;
    fsm_busy        = 1'b0;
    mem_en          = 1'b0;
    mem_addr        = '0;
    write_en0       = 1'b0;
    write_en1       = 1'b0;
    data_out        = '0;
    write_tag_array = 1'b0;
    tag_out         = '0;
    tag_way         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (miss_detected) begin
          base_d  = miss_addr[TAG_HI:SET_LO];
          way_d   = victim_way;
          issue_d = '0;
          recv_d  = '0;
          state_d = FILL;
        end
      end
      FILL: begin
        fsm_busy = 1'b1;
        if (!issue_q[3]) begin
          mem_en   = 1'b1;
          mem_addr = {base_q, issue_q[2:0], 1'b0};
          issue_d  = issue_q + 4'd1;
        end
        // a return with nothing outstanding is a protocol error and is dropped
        if (mem_data_valid && (issue_q != {1'b0, recv_q})) begin
          wr        = 1'b1;
          write_en0 = !way_q;
          write_en1 = way_q;
          data_out  = mem_data;
          recv_d    = recv_q + 3'd1;
          if (recv_q == 3'd7) state_d = DONE;
        end
      end
      DONE: begin
        fsm_busy        = 1'b1;
        write_tag_array = 1'b1;
        tag_out         = base_q[BASE_W-1 -: TAG_W];
        tag_way         = way_q;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  onehot_decoder #(.N(SET_BITS)) u_blk_dec (
    .en_i  (wr),
    .sel_i (base_q[SET_BITS-1:0]),
    .dec_o (block_enable)
  );

  onehot_decoder #(.N(WIDX_W)) u_word_dec (
    .en_i  (wr),
    .sel_i (recv_q),
    .dec_o (word_enable)
  );

endmodule

// File: tb/tb_cache_fill_fsm.sv
`timescale 1ns/1ps
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        miss_detected = 1'b0;
  logic [15:0] miss_addr = '0;
  logic        victim_way = 1'b0;
  logic        mem_data_valid = 1'b0;
  logic [15:0] mem_data = '0;
  logic        fsm_busy, mem_en, write_en0, write_en1, write_tag_array, tag_way;
  logic [15:0] mem_addr, data_out;
  logic [63:0] block_enable;
  logic [7:0]  word_enable;
  logic [5:0]  tag_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cache_fill_fsm #(.NSETS(64)) dut (
    .clk(clk), .rst(rst),
    .miss_detected(miss_detected), .miss_addr(miss_addr), .victim_way(victim_way),
    .mem_data_valid(mem_data_valid), .mem_data(mem_data),
    .fsm_busy(fsm_busy), .mem_en(mem_en), .mem_addr(mem_addr),
    .block_enable(block_enable), .word_enable(word_enable),
    .write_en0(write_en0), .write_en1(write_en1), .data_out(data_out),
    .write_tag_array(write_tag_array), .tag_out(tag_out), .tag_way(tag_way)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " busy"}, fsm_busy, 0);
    chk({tag, " men"},  mem_en, 0);
    chk({tag, " maddr"}, mem_addr, 0);
    chk({tag, " blk"},  block_enable, 0);
    chk({tag, " word"}, word_enable, 0);
    chk({tag, " we0"},  write_en0, 0);
    chk({tag, " we1"},  write_en1, 0);
    chk({tag, " dout"}, data_out, 0);
    chk({tag, " wtag"}, write_tag_array, 0);
    chk({tag, " tag"},  tag_out, 0);
    chk({tag, " tway"}, tag_way, 0);
  endtask

  // One full fill from its cycle 0 (miss sampled) through DONE. Valids start
  // at cycle 5 (MEM_LAT=4 after the first request) and repeat every 'stride'.
  task automatic fill(input string nm, input logic [15:0] addr, input logic way,
                      input logic [63:0] exp_blk, input logic [5:0] exp_tag,
                      input int stride, input logic hold, input logic stray);
    int n = 0;
    int wcnt = 0;
    int last = 5 + stride * 7;
    @(posedge clk); #1;
    miss_detected = 1'b1; miss_addr = addr; victim_way = way; mem_data_valid = 1'b0;
    #1;
    chk({nm, " c0 busy"}, fsm_busy, 0);
    chk({nm, " c0 men"}, mem_en, 0);
    for (int c = 1; c <= last + 1; c++) begin
      logic v;
      @(posedge clk); #1;
      v = (c >= 5) && (((c - 5) % stride) == 0) && (n < 8);
      miss_detected  = hold;
      mem_data_valid = v || (stray && c == 1);
      mem_data       = 16'hA000 + 16'(n);
      #1;
      chk($sformatf("%s c%0d busy", nm, c), fsm_busy, 1);
      chk($sformatf("%s c%0d men", nm, c), mem_en, c <= 8);
      chk($sformatf("%s c%0d maddr", nm, c), mem_addr,
          (c <= 8) ? {addr[15:4], 3'(c - 1), 1'b0} : 16'h0);
      chk($sformatf("%s c%0d we0", nm, c), write_en0, v && !way);
      chk($sformatf("%s c%0d we1", nm, c), write_en1, v && way);
      chk($sformatf("%s c%0d blk", nm, c), block_enable, v ? exp_blk : 64'h0);
      chk($sformatf("%s c%0d word", nm, c), word_enable, v ? (8'h01 << n) : 8'h00);
      chk($sformatf("%s c%0d dout", nm, c), data_out, v ? 16'hA000 + 16'(n) : 16'h0);
      chk($sformatf("%s c%0d wtag", nm, c), write_tag_array, c == last + 1);
      chk($sformatf("%s c%0d tag", nm, c), tag_out, (c == last + 1) ? exp_tag : 6'h0);
      chk($sformatf("%s c%0d tway", nm, c), tag_way, (c == last + 1) && way);
      if (write_en0 || write_en1) wcnt++;
      if (v) n++;
    end
    mem_data_valid = 1'b0;
    chk({nm, " nwrites"}, wcnt, 8);
  endtask

  initial begin
    // reset state
    #2; chk_idle("reset");
    #20; @(posedge clk); #1; rst = 1'b1;

    // stray valids with no miss: no writes
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      mem_data_valid = 1'b1; mem_data = 16'hDEAD; #1;
      chk_idle($sformatf("stray_idle%0d", c));
    end
    mem_data_valid = 1'b0;

    // basic fill: set 35, tag 4, way 0
    fill("basic", 16'h1234, 1'b0, 64'h0000_0008_0000_0000, 6'h04, 1, 1'b0, 1'b0);
    @(posedge clk); #1; #1;
    chk_idle("basic_c14");

    // way 1, set 63, tag 0x3F
    fill("way1", 16'hFFF0, 1'b1, 64'h8000_0000_0000_0000, 6'h3F, 1, 1'b0, 1'b0);

    // gapped returns (1,0,0,...) plus a valid with nothing outstanding in cycle 1
    fill("stall", 16'h1234, 1'b0, 64'h0000_0008_0000_0000, 6'h04, 3, 1'b0, 1'b1);

    // miss held through the fill, then a back-to-back fill with new address/way
    fill("hold", 16'hFFF0, 1'b1, 64'h8000_0000_0000_0000, 6'h3F, 1, 1'b1, 1'b0);
    fill("b2b", 16'h0A50, 1'b1, 64'h0000_0020_0000_0000, 6'h02, 1, 1'b0, 1'b0);

    // reset in cycle 6 of a fill; late returns in cycles 7-12 are dropped
    @(posedge clk); #1;
    miss_detected = 1'b1; miss_addr = 16'h1234; victim_way = 1'b0; #1;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      miss_detected = 1'b0; mem_data_valid = (c == 5); mem_data = 16'hA000;
    end
    @(posedge clk); #1;
    mem_data_valid = 1'b1; mem_data = 16'hA001; rst = 1'b0; #1;
    chk_idle("rst_c6");
    for (int c = 7; c <= 12; c++) begin
      @(posedge clk); #1;
      rst = 1'b1; mem_data_valid = 1'b1; mem_data = 16'hA000 + 16'(c - 5); #1;
      chk_idle($sformatf("late_c%0d", c));
    end
    mem_data_valid = 1'b0;
    fill("post_rst", 16'h1234, 1'b0, 64'h0000_0008_0000_0000, 6'h04, 1, 1'b0, 1'b0);

    @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
